// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - two-requester round-robin sequencer for a sliced N x W accumulating multiplier
//
// Accepts one operation at a time from two requesters, clears the external
// datapath for one cycle, feeds the b operand to it W bits at a time (LSB
// slice first) over CC cycles, captures the 2N-bit product, and holds it
// until the consumer takes it.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req0_valid/ready/a/b        requester 0 handshake and operands
//   req1_valid/ready/a/b        requester 1 handshake and operands
//   res_valid/ready/data/id     result handshake, product, owning requester
//   busy                        high whenever an operation is in flight
//   dp_rst                      one-cycle clear to the datapath accumulator
//   dp_g                        full-width a operand to the datapath
//   dp_e                        current W-bit slice of b to the datapath
//   dp_o                        datapath sum output
module mult_seq_ctrl #(
  parameter int N  = 128,
  parameter int CC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_a,
  input  logic [N-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_a,
  input  logic [N-1:0]     req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res_data,
  output logic             res_id,
  output logic             busy,
  output logic             dp_rst,
  output logic [N-1:0]     dp_g,
  output logic [N/CC-1:0]  dp_e,
  input  logic [2*N-1:0]   dp_o
);

  localparam int W  = N / CC;
  localparam int KW = $clog2(CC);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic          last;       // requester granted most recently
  logic [N-1:0]  b_q;
  logic          id_q;
  logic          grant_id;
  logic          accept;
  logic          k_last;

  // Tie goes to whoever was not granted last; otherwise the lone valid wins.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last;
    end
  end

  // Gated by rst so no handshake can be seen while reset is held.
  assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && !rst && req1_valid && grant_id;
  assign accept     = req0_ready | req1_ready;
  assign k_last     = (k == KW'(CC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    res_valid = (state == DONE);
    dp_e      = '0;
    case (state)
      IDLE: if (accept) state_nxt = CLR;
      CLR:  state_nxt = RUN;
      RUN: begin
        dp_e = W'(b_q >> (int'(k) * W));
        if (k_last) state_nxt = DONE;
      end
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      last     <= 1'b1;
      dp_rst   <= 1'b0;
      dp_g     <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      res_data <= '0;
      res_id   <= 1'b0;
    end else begin
      // accept only happens in IDLE, so this lands exactly on the CLR cycle
      dp_rst <= accept;
      if (accept) begin
        dp_g <= req1_ready ? req1_a : req0_a;
        b_q  <= req1_ready ? req1_b : req0_b;
        id_q <= req1_ready;
        last <= req1_ready;
      end
      if (state == RUN) begin
        k <= k_last ? '0 : k + 1'b1;
        if (k_last) begin
          res_data <= dp_o;
          res_id   <= id_q;
        end
      end else begin
        k <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - randomized self-checking bench for mult_seq_ctrl with behavioural datapath
module tb_mult_seq_ctrl;

  localparam int N  = 8;
  localparam int CC = 4;
  localparam int W  = N / CC;
  localparam int DW = 2 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          res_valid, res_ready, res_id, busy, dp_rst;
  logic [DW-1:0] res_data, dp_o;
  logic [N-1:0]  dp_g;
  logic [W-1:0]  dp_e;

  mult_seq_ctrl #(.N(N), .CC(CC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .dp_rst(dp_rst), .dp_g(dp_g), .dp_e(dp_e), .dp_o(dp_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Behavioural accumulating datapath: slice j of b is weighted by 2^(j*W).
  logic [DW-1:0] dp_acc = '0;
  int            dp_cnt = 0;
  always @(posedge clk) begin
    if (dp_rst) begin
      dp_acc <= '0;
      dp_cnt <= 0;
    end else begin
      dp_acc <= dp_o;
      dp_cnt <= dp_cnt + 1;
    end
  end
  always_comb dp_o = dp_acc + ((DW'(dp_g) * DW'(dp_e)) << (dp_cnt * W));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  bit            m_busy = 0;
  int            m_t = 0;
  logic [DW-1:0] m_prod = '0;
  logic          m_id = 0;
  logic [N-1:0]  m_a = '0, m_b = '0;
  bit            m_last = 1;
  int            starve[2] = '{0, 0};
  int            accepted = 0;
  bit            acc0 = 0, acc1 = 0;
  logic [DW-1:0] last_data = '0;
  logic          last_id = 0;
  int            last_lat = 0;
  int            first_acc_cyc = -1;
  logic [DW-1:0] data_log[$];
  logic          id_log[$];

  always @(negedge clk) begin : mon
    bit           g, e_r0, e_r1, e_rv, gid;
    int           kk;
    logic [W-1:0] e_e;
    acc0 = 0;
    acc1 = 0;
    if (rst) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dp_e", dp_e, 0);
      chk("rst_dp_rst", dp_rst, 0);
      chk("rst_dp_g", dp_g, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_id", res_id, 0);
      m_busy = 0;
      m_last = 1;
      m_a    = '0;
      starve = '{0, 0};
    end else begin
      e_r0 = 0;
      e_r1 = 0;
      if (!m_busy) begin
        g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e_r0 = req0_valid && !g;
        e_r1 = req1_valid && g;
      end
      chk("ready0", req0_ready, e_r0);
      chk("ready1", req1_ready, e_r1);
      chk("busy", busy, m_busy);
      chk("dp_g", dp_g, m_a);
      e_rv = m_busy && (cyc - m_t >= CC + 2);
      chk("res_valid", res_valid, e_rv);
      if (e_rv) begin
        chk("res_data", res_data, m_prod);
        chk("res_id", res_id, m_id);
      end
      kk  = cyc - m_t - 2;
      e_e = (m_busy && kk >= 0 && kk < CC) ? W'(m_b >> (kk * W)) : '0;
      chk("dp_e", dp_e, e_e);
      chk("dp_rst", dp_rst, m_busy && (cyc == m_t + 1));
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0 || acc1) begin
        gid = acc1;
        starve[gid] = 0;
        if (gid ? req0_valid : req1_valid) begin
          starve[!gid]++;
          chk("starve", starve[!gid] <= 1, 1);
        end else begin
          starve[!gid] = 0;
        end
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        m_busy   = 1;
        m_t      = cyc;
        m_id     = gid;
        m_a      = gid ? req1_a : req0_a;
        m_b      = gid ? req1_b : req0_b;
        m_prod   = DW'(m_a) * DW'(m_b);
        m_last   = gid;
        accepted++;
      end else if (e_rv && res_ready) begin
        last_data = res_data;
        last_id   = res_id;
        last_lat  = cyc - m_t;
        data_log.push_back(res_data);
        id_log.push_back(res_id);
        m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0) req0_valid = 1'b0;
    if (acc1) req1_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while ((m_busy || req0_valid || req1_valid) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, n < 200, 1);
  endtask

  function automatic logic [N-1:0] rand_op();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    return N'($urandom);
  endfunction

  int rel_cyc, acc_before, acc_start, issued, n;

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = cyc;

    // First accept directly after reset, small product and its latency
    res_ready = 1;
    req0_a = 8'h03; req0_b = 8'h05; req0_valid = 1;
    wait_quiet("t029");
    chk("first_accept_cycle", first_acc_cyc, rel_cyc);
    chk("t029_data", last_data, 16'h000F);
    chk("t029_id", last_id, 0);
    chk("t029_latency", last_lat, CC + 2);

    // All-ones operands from requester 1
    req1_a = 8'hFF; req1_b = 8'hFF; req1_valid = 1;
    wait_quiet("t030");
    chk("t030_data", last_data, 16'hFE01);
    chk("t030_id", last_id, 1);

    // Tie from reset: requester 0 first, then requester 1
    rst = 1'b1;
    req0_a = 8'h10; req0_b = 8'h10; req0_valid = 1;
    req1_a = 8'h10; req1_b = 8'h10; req1_valid = 1;
    tick(); tick();
    rst = 1'b0;
    data_log.delete();
    id_log.delete();
    wait_quiet("t031");
    chk("t031_count", data_log.size(), 2);
    if (data_log.size() == 2) begin
      chk("t031_id0", id_log[0], 0);
      chk("t031_id1", id_log[1], 1);
      chk("t031_data0", data_log[0], 16'h0100);
      chk("t031_data1", data_log[1], 16'h0100);
    end

    // Consumer stalls in DONE while requester 0 waits
    res_ready = 0;
    req1_a = 8'h21; req1_b = 8'h43; req1_valid = 1;
    n = 0;
    while (!(m_busy && cyc - m_t >= CC + 2) && n < 50) begin tick(); n++; end
    chk("t032_reach_done", n < 50, 1);
    acc_before = accepted;
    req0_a = 8'h07; req0_b = 8'h09; req0_valid = 1;
    repeat (10) tick();
    chk("t032_no_accept_in_done", accepted, acc_before);
    res_ready = 1;
    wait_quiet("t032");
    chk("t032_accept_after", accepted, acc_before + 1);
    chk("t032_data", last_data, 16'h003F);

    // Reset in RUN at k=2 discards the operation
    req0_a = 8'hA7; req0_b = 8'h3C; req0_valid = 1;
    n = 0;
    while (!(m_busy && cyc == m_t + 4) && n < 50) begin tick(); n++; end
    chk("t033_reach_run", n < 50, 1);
    rst = 1'b1;
    #1;
    chk("t033_async_busy", busy, 0);
    chk("t033_async_res_valid", res_valid, 0);
    chk("t033_async_dp_e", dp_e, 0);
    tick();
    rst = 1'b0;
    req1_a = 8'h5A; req1_b = 8'hC3; req1_valid = 1;
    wait_quiet("t033");
    chk("t033_data", last_data, 16'h448E);
    chk("t033_id", last_id, 1);

    // Random back-to-back stress
    acc_start = accepted;
    issued = 0;
    for (int c = 0; c < 60000 && (accepted - acc_start) < 1000; c++) begin
      tick();
      res_ready = 1'($urandom);
      if (!req0_valid && issued < 1000 && $urandom_range(0, 1) == 1) begin
        req0_a = rand_op(); req0_b = rand_op(); req0_valid = 1; issued++;
      end else if (req0_valid && $urandom_range(0, 19) == 0) begin
        req0_valid = 0; issued--;
      end
      if (!req1_valid && issued < 1000 && $urandom_range(0, 1) == 1) begin
        req1_a = rand_op(); req1_b = rand_op(); req1_valid = 1; issued++;
      end else if (req1_valid && $urandom_range(0, 19) == 0) begin
        req1_valid = 0; issued--;
      end
    end
    res_ready = 1;
    wait_quiet("stress");
    chk("stress_ops", accepted - acc_start, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish required finish before 90000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 128: operand width in bits.
REQ-002 The block SHALL have parameter CC, default 4: cycles per multiplication. CC SHALL be at least 2 and SHALL divide N. Slice width W = N/CC.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid, req1_valid  input  1 each  requester i has an operation pending.
REQ-006 req0_ready, req1_ready  output  1 each  requester i's operation is accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  N each  operands of requester i.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 res_data  output  2N  product a*b (unsigned).
REQ-011 res_id  output  1  index of the requester that owns res_data.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 dp_rst  output  1  clear pulse to the accumulating N x W multiplier datapath.
REQ-014 dp_g  output  N  full-width operand to the datapath.
REQ-015 dp_e  output  W  operand slice to the datapath.
REQ-016 dp_o  input  2N  datapath sum output (combinational in dp_e/dp_g plus its accumulator).

Function
REQ-017 The FSM SHALL have four states: IDLE, CLR, RUN, DONE.
REQ-018 Grant: in IDLE, reqi_ready SHALL be high only for the granted valid requester; at most one ready is high per cycle; both readys are low outside IDLE.
REQ-019 Arbitration SHALL be round-robin.
- Exactly one valid requester: that requester is granted.
- Both valid: the requester not granted last is granted.
- The last-granted pointer updates only on an accepted handshake.
REQ-020 Accept: valid && ready in IDLE SHALL latch a into dp_g, latch b and the id internally, and move the FSM to CLR.
REQ-021 CLR SHALL last exactly one cycle with registered dp_rst=1, then move to RUN with the slice counter k=0.
REQ-022 RUN SHALL last exactly CC cycles.
- In cycle k: dp_e = b[(k+1)W-1 : kW] (LSB slice first) and dp_rst=0.
- In cycle k=CC-1: res_data <= dp_o and res_id <= latched id, then the FSM moves to DONE.
REQ-023 Outside RUN, dp_e SHALL be 0. dp_g SHALL hold the latched a until the next accept.
REQ-024 DONE SHALL hold res_valid=1 with res_data and res_id stable until res_ready=1, then return to IDLE. res_valid SHALL be 0 in every other state.
REQ-025 Latency: accept at cycle t gives res_valid first high at t+CC+2. Minimum spacing between accepts is CC+3 cycles.
REQ-026 Boundary cases:
- res_ready high before res_valid has no effect.
- A valid dropped before ready is ignored.
- A requester asserting valid during RUN waits; no requests are lost.
- Operands all-ones SHALL yield (2^N-1)^2 with no truncation.

Reset
REQ-027 While rst=1, and immediately on its assertion including mid-operation:
- FSM=IDLE, k=0, round-robin pointer = requester 1 (so requester 0 wins the first tie).
- dp_rst=0, dp_g=0, dp_e=0, res_data=0, res_id=0.
- res_valid=0, busy=0, both readys 0.
- Any in-flight operation SHALL be discarded.
REQ-028 The first accept SHALL be possible in the first cycle after rst deasserts.

Verification (N=8, CC=4, behavioural datapath model attached)
REQ-029 req0 a=8'h03, b=8'h05 -> res_valid at accept+6, res_data=16'h000F, res_id=0.
REQ-030 req1 a=8'hFF, b=8'hFF -> res_data=16'hFE01, res_id=1.
REQ-031 Both valid from reset, each with a=8'h10, b=8'h10 -> req0 granted first, req1 second; results 16'h0100 with res_id 0 then 1.
REQ-032 res_ready held low 10 cycles in DONE -> res_valid and res_data stable throughout, both readys stay 0, and a pending req0 is accepted only after the handshake.
REQ-033 rst asserted in RUN at k=2 -> next sample shows res_valid=0, busy=0, dp_e=0; a new request then returns the correct product.
REQ-034 Random back-to-back stress, 1000 operations with random res_ready -> every result matches a*b with the correct id, and no requester is starved for more than one competing grant.
